// File: rtl/row_cfg_pkg.sv
// Shared constants, state encodings and the serial CRC step for row configuration loading.
package row_cfg_pkg;

    localparam int unsigned ROW_CHAIN_LEN = 1024;
    localparam int unsigned ROW_WORD_W    = 32;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_CRC  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // MSB-feedback serial CRC-16-CCITT, one bit per call.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Single-word buffer that shifts a bitstream word LSB-first onto the row programming chain.
module cfg_word_serializer
    import row_cfg_pkg::*;
#(
    parameter int unsigned WORD_W = ROW_WORD_W
) (
    input  logic              prog_clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load_en,
    input  logic              arm,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              prog_en,
    output logic              prog_in
);

    localparam int unsigned IDX_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sreg_q;
    logic [WORD_W-1:0] sreg_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic              full_d;
    logic              ready_d;

    // prog_en doubles as the buffer-full flag; prog_in is always the buffer LSB.
    always_comb begin
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        full_d  = prog_en;
        ready_d = 1'b0;
        if (flush) begin
            full_d = 1'b0;
            idx_d  = '0;
        end else if (prog_en) begin
            sreg_d = sreg_q >> 1;
            idx_d  = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(WORD_W - 1)) begin
                full_d = 1'b0;
                idx_d  = '0;
            end
        end else if (load_en && word_valid && word_ready) begin
            sreg_d = word_data;
            full_d = 1'b1;
            idx_d  = '0;
        end
        ready_d = arm && !full_d;
    end

    always_ff @(posedge prog_clk) begin
        if (!rst) begin
            sreg_q     <= '0;
            idx_q      <= '0;
            prog_en    <= 1'b0;
            word_ready <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            idx_q      <= idx_d;
            prog_en    <= full_d;
            word_ready <= ready_d;
        end
    end

    assign prog_in = sreg_q[0];

endmodule

// File: rtl/row_cfg_loader.sv
// Row configuration controller: streams CHAIN_LEN bits into the chain, checks the CRC trailer, gates the fabric.
module row_cfg_loader
    import row_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = ROW_CHAIN_LEN,
    parameter int unsigned WORD_W    = ROW_WORD_W,
    parameter logic [15:0] CRC_INIT  = CRC16_INIT
) (
    input  logic                               prog_clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [WORD_W-1:0]                  word_data,
    input  logic                               word_valid,
    output logic                               word_ready,
    output logic                               prog_en,
    output logic                               prog_in,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic                               fabric_hold,
    output logic [$clog2(CHAIN_LEN + 1)-1:0]   bit_count
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] bit_count_d;
    logic [15:0]      crc_q;
    logic [15:0]      crc_d;
    logic             busy_d;
    logic             done_d;
    logic             err_d;
    logic             hold_d;
    logic             flush_c;
    logic             shift_c;
    logic             xfer_c;
    logic             load_en_c;

    cfg_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .prog_clk   (prog_clk),
        .rst        (rst),
        .flush      (flush_c),
        .load_en    (load_en_c),
        .arm        (busy_d),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .prog_en    (prog_en),
        .prog_in    (prog_in)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count;
        crc_d       = crc_q;
        flush_c     = 1'b0;
        xfer_c      = word_valid && word_ready;
        shift_c     = (state_q == ST_LOAD) && prog_en;
        load_en_c   = (state_q == ST_LOAD);
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    bit_count_d = '0;
                    crc_d       = CRC_INIT;
                    flush_c     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (shift_c) begin
                    bit_count_d = bit_count + CNT_W'(1);
                    crc_d       = crc16_step(crc_q, prog_in);
                    // Last chain bit: drop the rest of the word and expect the trailer.
                    if (bit_count == CNT_W'(CHAIN_LEN - 1)) begin
                        state_d = ST_CRC;
                        flush_c = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                if (xfer_c) begin
                    state_d = (word_data[15:0] == crc_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_CRC);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
        hold_d = (state_d != ST_DONE);
    end

    always_ff @(posedge prog_clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_count   <= '0;
            crc_q       <= CRC_INIT;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            fabric_hold <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_count   <= bit_count_d;
            crc_q       <= crc_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            fabric_hold <= hold_d;
        end
    end

endmodule

// File: tb/tb_row_cfg_loader.sv
// Scoreboard bench for row_cfg_loader: a 40-bit chain instance and a 32-bit chain instance.
module tb_row_cfg_loader;

    logic        prog_clk = 1'b0;
    logic        rst;
    logic        start;
    logic        word_valid;
    logic [31:0] word_data;
    bit          sel;

    logic       start_a, ready_a, en_a, in_a, busy_a, done_a, err_a, hold_a;
    logic       start_b, ready_b, en_b, in_b, busy_b, done_b, err_b, hold_b;
    logic [5:0] bc_a, bc_b;

    logic       ready_m, en_m, in_m, busy_m, done_m, err_m, hold_m;
    logic [5:0] bc_m;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign ready_m = sel ? ready_b : ready_a;
    assign en_m    = sel ? en_b    : en_a;
    assign in_m    = sel ? in_b    : in_a;
    assign busy_m  = sel ? busy_b  : busy_a;
    assign done_m  = sel ? done_b  : done_a;
    assign err_m   = sel ? err_b   : err_a;
    assign hold_m  = sel ? hold_b  : hold_a;
    assign bc_m    = sel ? bc_b    : bc_a;

    row_cfg_loader #(.CHAIN_LEN(40), .WORD_W(32), .CRC_INIT(16'hFFFF)) dut_a (
        .prog_clk(prog_clk), .rst(rst), .start(start_a), .word_data(word_data),
        .word_valid(word_valid), .word_ready(ready_a), .prog_en(en_a), .prog_in(in_a),
        .busy(busy_a), .done(done_a), .err(err_a), .fabric_hold(hold_a), .bit_count(bc_a)
    );

    row_cfg_loader #(.CHAIN_LEN(32), .WORD_W(32), .CRC_INIT(16'hFFFF)) dut_b (
        .prog_clk(prog_clk), .rst(rst), .start(start_b), .word_data(word_data),
        .word_valid(word_valid), .word_ready(ready_b), .prog_en(en_b), .prog_in(in_b),
        .busy(busy_b), .done(done_b), .err(err_b), .fabric_hold(hold_b), .bit_count(bc_b)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct packed {
        logic       done;
        logic       err;
        logic       hold;
        logic       ready;
        logic       busy;
        logic [5:0] bc;
        logic [7:0] shifts;
    } res_t;

    logic        exp_bits[$];
    res_t        exp_res[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          shift_cnt = 0;
    logic        busy_prev = 1'b0;
    logic [5:0]  bc_prev = 6'd0;
    res_t        mon_r;
    logic [15:0] m_crc;
    int          pushed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] tb_crc_step(input logic [15:0] c, input logic b);
        logic [15:0] n;
        n = c << 1;
        if (c[15] ^ b) n = n ^ 16'h1021;
        return n;
    endfunction

    function automatic res_t mk_res(input logic d, input logic e, input logic h,
                                    input int bc, input int shifts);
        res_t r;
        r.done   = d;
        r.err    = e;
        r.hold   = h;
        r.ready  = 1'b0;
        r.busy   = 1'b0;
        r.bc     = 6'(bc);
        r.shifts = 8'(shifts);
        return r;
    endfunction

    // Monitor: checks every shifted bit and the settled outputs whenever a pass ends.
    always @(negedge prog_clk) begin
        if (en_m) begin
            shift_cnt++;
            if (exp_bits.size() == 0) check("extra_shift", 32'(en_m), 32'd0);
            else check("prog_in", 32'(in_m), 32'(exp_bits.pop_front()));
        end
        if (busy_m && busy_prev) check("bc_monotonic", 32'(bc_m >= bc_prev), 32'd1);
        if (busy_prev && !busy_m) begin
            if (exp_res.size() == 0) begin
                check("unexpected_end", 32'(exp_res.size()), 32'd1);
            end else begin
                mon_r = exp_res.pop_front();
                check("end_done",   32'(done_m),  32'(mon_r.done));
                check("end_err",    32'(err_m),   32'(mon_r.err));
                check("end_hold",   32'(hold_m),  32'(mon_r.hold));
                check("end_ready",  32'(ready_m), 32'(mon_r.ready));
                check("end_busy",   32'(busy_m),  32'(mon_r.busy));
                check("end_bc",     32'(bc_m),    32'(mon_r.bc));
                check("end_shifts", 32'(shift_cnt), 32'(mon_r.shifts));
            end
            shift_cnt = 0;
        end
        busy_prev = busy_m;
        bc_prev   = bc_m;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        word_data  = w;
        word_valid = 1'b1;
        while (!ready_m && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        if (!ready_m) check("ready_timeout", 32'(ready_m), 32'd1);
        else begin
            @(posedge prog_clk);
            #1;
        end
        word_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_m && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        if (!ready_m) check("wait_ready_timeout", 32'(ready_m), 32'd1);
    endtask

    task automatic wait_bc(input int target);
        int n = 0;
        while (bc_m != 6'(target) && n < 300) begin
            @(negedge prog_clk);
            n++;
        end
        if (bc_m != 6'(target)) check("bc_timeout", 32'(bc_m), 32'(target));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_m && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        if (busy_m) check("idle_timeout", 32'(busy_m), 32'd0);
    endtask

    task automatic push_word(input logic [31:0] w, input int chain);
        for (int i = 0; i < 32; i++) begin
            if (pushed < chain) begin
                exp_bits.push_back(w[i]);
                m_crc = tb_crc_step(m_crc, w[i]);
                pushed++;
            end
        end
    endtask

    task automatic run_pass(input logic [31:0] w1, input logic [31:0] w2, input int nwords,
                            input logic [15:0] crc_xor, input bit gap, input bit glitch,
                            input int chain);
        m_crc  = 16'hFFFF;
        pushed = 0;
        push_word(w1, chain);
        if (nwords > 1) push_word(w2, chain);
        exp_res.push_back(mk_res(crc_xor == 16'h0, crc_xor != 16'h0, crc_xor != 16'h0,
                                 chain, chain));
        @(negedge prog_clk);
        pulse_start();
        send_word(w1);
        if (glitch) begin
            repeat (5) @(negedge prog_clk);
            check("glitch_load_busy", 32'(busy_m), 32'd1);
            pulse_start();
        end
        if (nwords > 1) begin
            if (gap) begin
                wait_ready();
                for (int i = 0; i < 10; i++) begin
                    check("gap_prog_en", 32'(en_m), 32'd0);
                    check("gap_bit_count", 32'(bc_m), 32'd32);
                    @(negedge prog_clk);
                end
            end
            send_word(w2);
        end
        wait_bc(chain);
        check("crc_entry_ready", 32'(ready_m), 32'd1);
        check("crc_entry_prog_en", 32'(en_m), 32'd0);
        check("crc_entry_busy", 32'(busy_m), 32'd1);
        if (glitch) begin
            pulse_start();
            check("glitch_crc_bc", 32'(bc_m), 32'(chain));
            check("glitch_crc_ready", 32'(ready_m), 32'd1);
        end
        send_word({16'hDEAD, m_crc ^ crc_xor});
        wait_idle();
        repeat (2) @(negedge prog_clk);
        check("bits_left", 32'(exp_bits.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        word_data  = 32'h0;
        sel        = 1'b0;
        repeat (3) @(negedge prog_clk);
        check("rst_ready",  32'(ready_a), 32'd0);
        check("rst_prog_en", 32'(en_a),   32'd0);
        check("rst_prog_in", 32'(in_a),   32'd0);
        check("rst_busy",   32'(busy_a),  32'd0);
        check("rst_done",   32'(done_a),  32'd0);
        check("rst_err",    32'(err_a),   32'd0);
        check("rst_hold",   32'(hold_a),  32'd1);
        check("rst_bc",     32'(bc_a),    32'd0);
        check("rst_hold_b", 32'(hold_b),  32'd1);
        check("rst_busy_b", 32'(busy_b),  32'd0);
        rst = 1'b1;
        @(negedge prog_clk);

        // Nominal pass, bad trailer, then a source gap between payload words.
        run_pass(32'hA5A5A5A5, 32'h000000FF, 2, 16'h0000, 1'b0, 1'b0, 40);
        run_pass(32'hA5A5A5A5, 32'h000000FF, 2, 16'h0001, 1'b0, 1'b0, 40);
        run_pass(32'hA5A5A5A5, 32'h000000FF, 2, 16'h0000, 1'b1, 1'b0, 40);

        // Reset partway through a pass, then a full pass.
        m_crc  = 16'hFFFF;
        pushed = 0;
        push_word(32'hA5A5A5A5, 40);
        exp_res.push_back(mk_res(1'b0, 1'b0, 1'b1, 0, 21));
        @(negedge prog_clk);
        pulse_start();
        send_word(32'hA5A5A5A5);
        wait_bc(20);
        rst = 1'b0;
        @(negedge prog_clk);
        rst = 1'b1;
        check("midrst_prog_in", 32'(in_a), 32'd0);
        check("midrst_prog_en", 32'(en_a), 32'd0);
        check("midrst_ready",   32'(ready_a), 32'd0);
        @(negedge prog_clk);
        exp_bits.delete();
        run_pass(32'hA5A5A5A5, 32'h000000FF, 2, 16'h0000, 1'b0, 1'b0, 40);

        // Start pulses while loading and while waiting for the trailer.
        run_pass(32'hA5A5A5A5, 32'h000000FF, 2, 16'h0000, 1'b0, 1'b1, 40);

        // Chain length equal to one word.
        sel = 1'b1;
        @(negedge prog_clk);
        run_pass(32'hFFFFFFFF, 32'h0, 1, 16'h0000, 1'b0, 1'b0, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
